reg_op_sequencer: RTL and testbench

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// Sequences LDI/MOV/ALU/ACC commands into register-memory read/write/function strobes; LDI 2, MOV 3+READ_LAT, ALU 3, ACC 7+2*READ_LAT cycles to done.
// cmd_ready only in IDLE, no queueing. Optional SEQ_OP_COUNT_EN adds a saturating op_count output.
module reg_op_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic [1:0]        cmd_fn,
    output logic [ADDR_W-1:0] rm_address,
    output logic              rm_read_en,
    output logic              rm_write_en,
    output logic [DATA_W-1:0] rm_data_in,
    output logic [1:0]        rm_select_fn,
    output logic              rm_fn_valid,
    input  logic [DATA_W-1:0] rm_data_out,
    input  logic [3:0]        rm_flag,
    output logic              done,
    output logic              busy,
    output logic [3:0]        flag_q
`ifdef SEQ_OP_COUNT_EN
   ,output logic [7:0]        op_count
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_FN     = 3'd4;
    localparam logic [2:0] S_FNWAIT = 3'd5;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    logic [2:0]        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [1:0]        fn_q, fn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        flag_d;
    logic              done_q, done_d;
    logic              live_q;

    // live_q keeps cmd_ready low until the first edge with reset released
    assign cmd_ready    = (state_q == S_IDLE) && live_q;
    assign busy         = (state_q != S_IDLE);
    assign rm_read_en   = (state_q == S_RD);
    assign rm_write_en  = (state_q == S_WR);
    assign rm_fn_valid  = (state_q == S_FN);
    assign rm_address   = addr_q;
    assign rm_data_in   = data_q;
    assign rm_select_fn = sel_q;
    assign done         = done_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dst_d   = dst_q;
        fn_d    = fn_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    fn_d    = cmd_fn;
                    phase_d = 2'd0;
                    case (cmd_op)
                        OP_LDI: begin
                            state_d = S_WR;
                            addr_d  = cmd_dst;
                            data_d  = cmd_imm;
                        end
                        OP_ALU: begin
                            state_d = S_FN;
                            sel_d   = cmd_fn;
                        end
                        default: begin
                            state_d = S_RD;
                            addr_d  = cmd_src;
                        end
                    endcase
                end
            end
            S_RD: begin
                state_d = S_RDWAIT;
                cnt_d   = CNT_W'(READ_LAT - 1);
            end
            S_RDWAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_WR;
                    data_d  = rm_data_out;
                    // ACC moves src->R1 first, then R2->R0
                    if (op_q == OP_ACC) begin
                        addr_d = (phase_q == 2'd0) ? ADDR_W'(1) : ADDR_W'(0);
                    end else begin
                        addr_d = dst_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR: begin
                if (op_q == OP_ACC && phase_q == 2'd0) begin
                    state_d = S_FN;
                    sel_d   = fn_q;
                    phase_d = 2'd1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FN: begin
                state_d = S_FNWAIT;
            end
            S_FNWAIT: begin
                flag_d = rm_flag;
                if (op_q == OP_ACC) begin
                    state_d = S_RD;
                    addr_d  = ADDR_W'(2);
                    phase_d = 2'd2;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            fn_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            flag_q  <= '0;
            done_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            fn_q    <= fn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            live_q  <= 1'b1;
        end
    end

`ifdef SEQ_OP_COUNT_EN
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (done_d && op_count_q != 8'hFF) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a small register-memory model driving rm_data_out.
module tb_reg_op_sequencer;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic [1:0]    cmd_fn = '0;
    logic [AW-1:0] rm_address;
    logic          rm_read_en;
    logic          rm_write_en;
    logic [DW-1:0] rm_data_in;
    logic [1:0]    rm_select_fn;
    logic          rm_fn_valid;
    logic [DW-1:0] rm_data_out;
    logic [3:0]    rm_flag = '0;
    logic          done;
    logic          busy;
    logic [3:0]    flag_q;
`ifdef SEQ_OP_COUNT_EN
    logic [7:0]    op_count;
`endif

    always #5 clk = ~clk;

    reg_op_sequencer #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_imm(cmd_imm), .cmd_fn(cmd_fn),
        .rm_address(rm_address), .rm_read_en(rm_read_en), .rm_write_en(rm_write_en),
        .rm_data_in(rm_data_in), .rm_select_fn(rm_select_fn), .rm_fn_valid(rm_fn_valid),
        .rm_data_out(rm_data_out), .rm_flag(rm_flag),
        .done(done), .busy(busy), .flag_q(flag_q)
`ifdef SEQ_OP_COUNT_EN
       ,.op_count(op_count)
`endif
    );

    // Register-memory model: preloaded while reset is held, written on rm_write_en
    logic [DW-1:0] mem [0:31];
    assign rm_data_out = mem[rm_address];
    always @(posedge clk) begin
        if (!rst) begin
            mem[5] <= 8'd208;
            mem[9] <= 8'd32;
            mem[2] <= 8'd173;
            mem[7] <= 8'd55;
        end else if (rm_write_en) begin
            mem[rm_address] <= rm_data_in;
        end
    end

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [DW-1:0] imm;
        logic [1:0]    fn;
        logic [3:0]    flag;
        int e_done, e_nwr, e_nrd, e_nfn, e_fwa, e_fwd, e_lwa, e_lwd, e_sel, e_flag;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    int nwr, nrd, nfn, fwa, fwd, lwa, lwd, sel, overlap, done_at, flag_at, rdy_at, busy_at;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe from cycle index 'start' (relative to the accept edge) until done or budget
    task automatic collect(input int start);
        nwr = 0; nrd = 0; nfn = 0; fwa = -1; fwd = -1; lwa = -1; lwd = -1;
        sel = -1; overlap = 0; done_at = -1; flag_at = -1; rdy_at = -1; busy_at = -1;
        for (int c = start; c <= 16; c++) begin
            if (rm_write_en) begin
                nwr++;
                if (nwr == 1) begin
                    fwa = int'(rm_address);
                    fwd = int'(rm_data_in);
                end
                lwa = int'(rm_address);
                lwd = int'(rm_data_in);
            end
            if (rm_read_en) nrd++;
            if (rm_fn_valid) begin
                nfn++;
                sel = int'(rm_select_fn);
            end
            if (int'(rm_write_en) + int'(rm_read_en) + int'(rm_fn_valid) > 1) overlap++;
            if (done) begin
                done_at = c;
                flag_at = int'(flag_q);
                rdy_at  = int'(cmd_ready);
                busy_at = int'(busy);
                break;
            end
            step();
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [DW-1:0] imm, input logic [1:0] fn);
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm; cmd_fn = fn;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_src = '1; cmd_dst = '1; cmd_imm = ~imm; cmd_fn = ~fn;
    endtask

    vec_t tv [8];
    int   quiet;

    initial begin
        tv[0] = '{2'b00, 5'd0, 5'd4, 8'd141, 2'd0, 4'hF, 2, 1, 0, 0, 4, 141, 4, 141, -1, 0};
        tv[1] = '{2'b10, 5'd0, 5'd0, 8'd0,   2'd0, 4'h5, 3, 0, 0, 1, -1, -1, -1, -1, 0, 5};
        tv[2] = '{2'b01, 5'd5, 5'd1, 8'd0,   2'd0, 4'hA, 4, 1, 1, 0, 1, 208, 1, 208, -1, 5};
        tv[3] = '{2'b10, 5'd0, 5'd0, 8'd0,   2'd2, 4'hA, 3, 0, 0, 1, -1, -1, -1, -1, 2, 10};
        tv[4] = '{2'b11, 5'd9, 5'd0, 8'd0,   2'd0, 4'h3, 9, 2, 2, 1, 1, 32, 0, 173, 0, 3};
        tv[5] = '{2'b01, 5'd7, 5'd7, 8'd0,   2'd0, 4'h0, 4, 1, 1, 0, 7, 55, 7, 55, -1, 3};
        tv[6] = '{2'b00, 5'd0, 5'd0, 8'd255, 2'd0, 4'h0, 2, 1, 0, 0, 0, 255, 0, 255, -1, 3};
        tv[7] = '{2'b11, 5'd5, 5'd0, 8'd0,   2'd3, 4'hC, 9, 2, 2, 1, 1, 208, 0, 173, 3, 12};

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_read_en", int'(rm_read_en), 0);
        chk("rst_write_en", int'(rm_write_en), 0);
        chk("rst_fn_valid", int'(rm_fn_valid), 0);
        chk("rst_address", int'(rm_address), 0);
        chk("rst_data_in", int'(rm_data_in), 0);
        chk("rst_select_fn", int'(rm_select_fn), 0);
        chk("rst_flag_q", int'(flag_q), 0);
        rst = 1'b1;
        step();
        chk("rel_cmd_ready", int'(cmd_ready), 1);

        // Table-driven commands, issued back to back on each done cycle
        for (int i = 0; i < 8; i++) begin
            rm_flag = tv[i].flag;
            issue(tv[i].op, tv[i].src, tv[i].dst, tv[i].imm, tv[i].fn);
            collect(1);
            chk($sformatf("v%0d_done_cycle", i), done_at, tv[i].e_done);
            chk($sformatf("v%0d_n_write", i), nwr, tv[i].e_nwr);
            chk($sformatf("v%0d_n_read", i), nrd, tv[i].e_nrd);
            chk($sformatf("v%0d_n_fn", i), nfn, tv[i].e_nfn);
            chk($sformatf("v%0d_overlap", i), overlap, 0);
            chk($sformatf("v%0d_ready_at_done", i), rdy_at, 1);
            chk($sformatf("v%0d_busy_at_done", i), busy_at, 0);
            chk($sformatf("v%0d_flag_q", i), flag_at, tv[i].e_flag);
            if (tv[i].e_nwr > 0) begin
                chk($sformatf("v%0d_first_wr_addr", i), fwa, tv[i].e_fwa);
                chk($sformatf("v%0d_first_wr_data", i), fwd, tv[i].e_fwd);
                chk($sformatf("v%0d_last_wr_addr", i), lwa, tv[i].e_lwa);
                chk($sformatf("v%0d_last_wr_data", i), lwd, tv[i].e_lwd);
            end
            if (tv[i].e_nfn > 0) chk($sformatf("v%0d_select_fn", i), sel, tv[i].e_sel);
        end

        // cmd_valid pulsed while busy must be ignored
        issue(2'b01, 5'd5, 5'd3, 8'd0, 2'd0);
        cmd_op = 2'b00; cmd_dst = 5'd6; cmd_imm = 8'd9; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        collect(2);
        chk("busy_ign_done_cycle", done_at, 4);
        chk("busy_ign_n_write", nwr, 1);
        chk("busy_ign_wr_addr", lwa, 3);
        chk("busy_ign_wr_data", lwd, 208);
        quiet = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            quiet += int'(rm_write_en) + int'(rm_read_en) + int'(rm_fn_valid) + int'(busy);
        end
        chk("busy_ign_quiet_after", quiet, 0);

        // Reset during ACC RDWAIT aborts without strobes or done
        rm_flag = 4'h7;
        issue(2'b11, 5'd9, 5'd0, 8'd0, 2'd0);
        chk("abort_rd_strobe", int'(rm_read_en), 1);
        step();
        chk("abort_in_rdwait_busy", int'(busy), 1);
        rst = 1'b0;
        step();
        chk("abort_rst_ready", int'(cmd_ready), 0);
        chk("abort_rst_busy", int'(busy), 0);
        quiet = int'(rm_write_en) + int'(rm_read_en) + int'(rm_fn_valid) + int'(done);
        rst = 1'b1;
        step();
        chk("abort_rel_ready", int'(cmd_ready), 1);
        chk("abort_flag_q", int'(flag_q), 0);
        for (int c = 0; c < 10; c++) begin
            quiet += int'(rm_write_en) + int'(rm_read_en) + int'(rm_fn_valid) + int'(done);
            step();
        end
        chk("abort_no_activity", quiet, 0);

        // Held cmd_valid: second LDI accepted on the done cycle of the first
        cmd_op = 2'b00; cmd_dst = 5'd10; cmd_imm = 8'd77; cmd_valid = 1'b1;
        step();
        cmd_dst = 5'd11; cmd_imm = 8'd88;
        chk("held_wr1_en", int'(rm_write_en), 1);
        chk("held_wr1_addr", int'(rm_address), 10);
        chk("held_wr1_data", int'(rm_data_in), 77);
        step();
        chk("held_done1", int'(done), 1);
        chk("held_ready1", int'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        chk("held_wr2_en", int'(rm_write_en), 1);
        chk("held_wr2_addr", int'(rm_address), 11);
        chk("held_wr2_data", int'(rm_data_in), 88);
        chk("held_busy2", int'(busy), 1);
        step();
        chk("held_done2", int'(done), 1);
`ifdef SEQ_OP_COUNT_EN
        chk("held_op_count", int'(op_count), 2);
`endif
        step();
        chk("held_done_pulse_ends", int'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
